// File: rtl/long_accum_pkg.sv
// Shared types and constants for the long accumulator framer and its core.
package long_accum_pkg;

    // Edges from the core data input to the edge at which that word is in the core sum.
    localparam int CORE_LAT = 4;

    // Carry-save segment widths, matched to the native adder width of each DSP family.
    localparam int SEG_W_AGILEX = 18;
    localparam int SEG_W_S10    = 27;

    // Framer control states.
    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        DRAIN   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/long_accumulator.sv
// Wide pipelined accumulator. Words are summed into short carry-save segments so
// no long carry chain sits in the accumulate loop; the carries are folded in by a
// two-step resolve pipeline behind it. The sum reflects a word CORE_LAT edges after
// the edge that registers it. clear empties every stage on the next edge.
module long_accumulator
    import long_accum_pkg::*;
#(
    parameter int    SIZE   = 256,
    parameter string FAMILY = "Agilex"
) (
    input  logic            clk,
    input  logic            clear,
    input  logic [SIZE-1:0] in_data,
    output logic [SIZE-1:0] sum
);

    localparam int SEG_W = (FAMILY == "Stratix 10") ? SEG_W_S10 : SEG_W_AGILEX;
    localparam int NSEG  = (SIZE + SEG_W - 1) / SEG_W;
    localparam int PAD_W = NSEG * SEG_W;
    localparam int LO_W  = PAD_W / 2;
    localparam int HI_W  = PAD_W - LO_W;

    logic [PAD_W-1:0] r_in;
    logic [SEG_W:0]   r_seg [NSEG];
    logic [PAD_W-1:0] w_lows;
    logic [PAD_W-1:0] w_carries;
    logic [LO_W-1:0]  r_lo;
    logic             r_lo_c;
    logic [HI_W-1:0]  r_hi_a;
    logic [HI_W-1:0]  r_hi_b;
    logic [SIZE-1:0]  r_res;
    logic [SIZE-1:0]  r_sum;

    // Split the segment state into its low bits and its pending carries, each carry
    // placed at the weight of the segment above it.
    always_comb begin
        w_lows    = '0;
        w_carries = '0;
        for (int i = 0; i < NSEG; i++) begin
            w_lows[i*SEG_W +: SEG_W] = r_seg[i][SEG_W-1:0];
            if (i < NSEG - 1) begin
                w_carries[(i+1)*SEG_W] = r_seg[i][SEG_W];
            end
        end
    end

    // Input register, zero-extended to a whole number of segments.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_in <= '0;
        end else begin
            r_in <= PAD_W'(in_data);
        end
    end

    // Carry-save accumulate: each segment adds its slice plus the carry left by the
    // segment below on the previous cycle, so the represented total is exact.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSEG; i++) begin
            if (clear) begin
                r_seg[i] <= '0;
            end else begin
                r_seg[i] <= {1'b0, r_seg[i][SEG_W-1:0]}
                          + {1'b0, r_in[i*SEG_W +: SEG_W]}
                          + {{SEG_W{1'b0}}, w_carries[i*SEG_W]};
            end
        end
    end

    // Resolve step one: low half fully added, high half operands carried along.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_lo   <= '0;
            r_lo_c <= 1'b0;
            r_hi_a <= '0;
            r_hi_b <= '0;
        end else begin
            {r_lo_c, r_lo} <= {1'b0, w_lows[LO_W-1:0]} + {1'b0, w_carries[LO_W-1:0]};
            r_hi_a         <= w_lows[PAD_W-1:LO_W];
            r_hi_b         <= w_carries[PAD_W-1:LO_W];
        end
    end

    // Resolve step two: high half plus the low-half carry; wraps modulo 2^SIZE.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_res <= '0;
        end else begin
            r_res <= SIZE'({r_hi_a + r_hi_b + HI_W'(r_lo_c), r_lo});
        end
    end

    // Output register so the framer's capture path starts from a flop.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_sum <= '0;
        end else begin
            r_sum <= r_res;
        end
    end

    assign sum = r_sum;

endmodule

// File: rtl/long_accum_framer.sv
// Frames a stream of wide unsigned words into per-frame sums. Words are accepted
// in ACCUM; after the last word the FSM waits in DRAIN for the core pipeline to
// settle and for the output slot to be free, then CAPTURE latches the sum and word
// count and clears the core for the next frame.
module long_accum_framer
    import long_accum_pkg::*;
#(
    parameter int    SIZE       = 256,
    parameter string FAMILY     = "Agilex",
    parameter int    RESULT_LAT = CORE_LAT,
    parameter int    COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               sclear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIZE-1:0]    in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE-1:0]    out_data,
    output logic [COUNT_W-1:0] out_count
);

    localparam int DRAIN_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [COUNT_W-1:0]   r_count;
    logic [DRAIN_W-1:0]   r_drain;
    logic                 r_out_valid;
    logic [SIZE-1:0]      r_out_data;
    logic [COUNT_W-1:0]   r_out_count;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_clear;
    logic [SIZE-1:0]      w_core_data;
    logic [SIZE-1:0]      w_core_sum;

    assign w_accept    = in_valid & in_ready;
    assign w_clear     = sclear | w_capture;
    // Idle cycles feed zeros so the core only ever sees accepted words.
    assign w_core_data = w_accept ? in_data : '0;

    long_accumulator #(
        .SIZE   (SIZE),
        .FAMILY (FAMILY)
    ) u_core (
        .clk     (clk),
        .clear   (w_clear),
        .in_data (w_core_data),
        .sum     (w_core_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (sclear) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DRAIN waits at zero while an unread result still occupies the slot.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ACCUM: begin
                if (w_accept && in_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_drain == '0) && (!r_out_valid || out_ready)) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    // State-decoded outputs: input handshake and the one-cycle capture pulse.
    always_comb begin
        in_ready  = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            ACCUM:   in_ready  = 1'b1;
            DRAIN:   in_ready  = 1'b0;
            CAPTURE: w_capture = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Word counter: saturating, cleared together with the core.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_count <= '0;
        end else if (w_accept && (r_count != {COUNT_W{1'b1}})) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    // Drain counter: covers the core latency after the last word of a frame.
    always_ff @(posedge clk) begin
        if (sclear) begin
            r_drain <= '0;
        end else if ((r_state == ACCUM) && w_accept && in_last) begin
            r_drain <= DRAIN_W'(RESULT_LAT - 1);
        end else if ((r_state == DRAIN) && (r_drain != '0)) begin
            r_drain <= r_drain - DRAIN_W'(1);
        end
    end

    // Result slot: loaded on capture, emptied when the consumer takes it.
    always_ff @(posedge clk) begin
        if (sclear) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_core_sum;
            r_out_count <= r_count;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    // A held result must not change until it is taken.
    a_hold_stable: assert property (@(posedge clk) disable iff (sclear)
        (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_out_data)
                                         && $stable(r_out_count)));

    // No word is ever accepted outside ACCUM.
    a_accept_in_accum: assert property (@(posedge clk) disable iff (sclear)
        w_accept |-> (r_state == ACCUM));

endmodule

// File: doc/long_accum_framer.md
LONG_ACCUM_FRAMER -- requirements
Module: long_accum_framer

Interface
REQ-001 SHALL have parameter SIZE, default 256: operand and result width in bits.
REQ-002 SHALL have parameter FAMILY, default "Agilex": "Agilex" or "Stratix 10", passed to the accumulator core.
REQ-003 SHALL have parameter RESULT_LAT, default 4: cycles from the clock edge accepting a word to the edge at which that word is reflected in the core sum output.
REQ-004 SHALL have parameter COUNT_W, default 16: width of the word counter.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port sclear, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1: input word present.
REQ-008 SHALL have port in_ready, output, 1: block accepts the word this cycle.
REQ-009 SHALL have port in_data, input, SIZE: unsigned addend.
REQ-010 SHALL have port in_last, input, 1: the word is the last of its frame; qualified by in_valid.
REQ-011 SHALL have port out_valid, output, 1: frame result held.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port out_data, output, SIZE: frame sum modulo 2^SIZE.
REQ-014 SHALL have port out_count, output, COUNT_W: number of words in the frame.

Function
REQ-015 A word SHALL be accepted on any edge where in_valid and in_ready are both high.
REQ-016 The core SHALL receive in_data on accepted cycles and all-zero data on every other cycle.
REQ-017 States SHALL be ACCUM, DRAIN and CAPTURE.
REQ-018 ACCUM: in_ready=1; each accepted word increments the word counter; an accepted word with in_last=1 moves to DRAIN and loads the drain counter with RESULT_LAT-1.
REQ-019 DRAIN: in_ready=0; the drain counter decrements to 0; at 0, the state moves to CAPTURE when out_valid=0 or out_ready=1, and otherwise holds at 0.
REQ-020 CAPTURE (one cycle): in_ready=0; out_data<=core sum, out_count<=counter+0, out_valid<=1; clear pulse to the core and word counter in the same edge; next state ACCUM.
REQ-021 The capture edge SHALL occur no earlier than RESULT_LAT edges after the edge accepting the last word; with no backpressure, out_valid SHALL rise exactly RESULT_LAT+1 edges after that edge.
REQ-022 out_valid SHALL fall on an edge with out_ready=1 unless the same edge is a capture edge, in which case it stays 1 with the new data.
REQ-023 out_data and out_count SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 A new frame SHALL be accepted in ACCUM while a previous result is still held.
REQ-025 Sum overflow SHALL wrap modulo 2^SIZE with no flag.
REQ-026 The word counter SHALL saturate at 2^COUNT_W-1.
REQ-027 A single-word frame (first word has in_last=1) SHALL be legal.
REQ-028 Frames SHALL never be empty.

Reset
REQ-029 sclear SHALL force state ACCUM, word counter 0, drain counter 0, out_valid 0, out_data 0 and out_count 0 on the next edge.
REQ-030 sclear SHALL also clear the core accumulator.
REQ-031 in_ready SHALL be 1 in the first cycle after reset.
REQ-032 sclear mid-frame or mid-drain SHALL discard the partial frame and emit no result.

Structure
REQ-033 Shared package long_accum_pkg SHALL hold the state enum type (ACCUM, DRAIN, CAPTURE) and the core latency constant used to derive RESULT_LAT.
REQ-034 There SHALL be one sub-module instance, long_accumulator (SIZE, FAMILY), driven by internal clear = sclear OR capture pulse.

Verification
REQ-035 Frame of words 1, 2, 3 (last on 3), out_ready=1 -> out_data=6, out_count=3; out_valid rises RESULT_LAT+1 edges after the edge accepting word 3.
REQ-036 Frame 0x3FFFF, 0x1 -> out_data=0x40000, out_count=2 (carry across the 18-bit segment boundary).
REQ-037 Frame (2^256-1), 1 -> out_data=0, out_count=2 (wrap).
REQ-038 Frame A=5 (single word), out_ready=0, then frame B=7, 8 -> A stays held while B is accepted; B waits in DRAIN; after out_ready=1, results arrive in order: 5/1, then 15/2.
REQ-039 sclear asserted during DRAIN of frame 9, 9, then frame 4 -> only result 4/1 appears.
